multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode and execution over several clocks and drives the mux selects that route the datapath's shifted values:
  - the shift-left-twice branch offset, through ALU source B;
  - the shift-left-twice 26-bit jump target, through the PC source mux.
- Adds a memory-ready handshake so that fetch, load and store cycles can stall on a slow memory.

Parameters:
- STATE_W, 4, width of the state register (12 states used).
- ALU_CTRL_W, 3, width of the ALU control code.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- opcode  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access this cycle.
- iord  output  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
- ir_write  output  1  load the instruction register.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALUOut, 1 = data register.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left twice.
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], shifted 26-bit field}.
- alu_control  output  ALU_CTRL_W  ALU operation.
- pc_en  output  1  PC load enable = pc_write | (branch & zero).
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state_dbg  output  STATE_W  current state, for debug.

Behaviour:
- Reset:
  - rst low forces FETCH immediately, without waiting for a clock edge.
  - All write strobes (ir_write, mem_write, reg_write, pc_en) are 0 while rst is low.
  - All other outputs take their FETCH values.
  - Asserting reset mid-instruction abandons that instruction; no partial write completes after rst falls.
- The state register updates on the rising clk edge. Outputs are decoded from state; the only mem_ready gating is the stalls listed below.
- Defaults: every output not listed for a state is 0.
- States and outputs:
  - FETCH: alu_src_b=01, alu_op=add; ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alu_src_b=11, alu_op=add (precomputes the branch target into ALUOut). Next state by opcode:
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BEQEX
    - addi -> ADDIEX
    - j -> JEX
    - any other opcode -> FETCH, with illegal_op=1 for this cycle.
  - MEMADR: alu_src_a=1, alu_src_b=10, add. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Holds until mem_ready=1, then MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1. Next state FETCH.
  - MEMWR: iord=1, mem_write=1. Holds (mem_write held high) until mem_ready=1, then FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=funct. Next state ALUWB.
  - ALUWB: reg_dst=1, reg_write=1. Next state FETCH.
  - BEQEX: alu_src_a=1, sub, branch=1, pc_src=01. Next state FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, add. Next state ADDIWB.
  - ADDIWB: reg_write=1. Next state FETCH.
  - JEX: pc_src=10, pc_write=1. Next state FETCH.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- ALU decode:
  - alu_op=add -> 010; alu_op=sub -> 110.
  - alu_op=funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - any other funct -> 010.
- Latency with mem_ready tied high: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Unused state encodings go to FETCH on the next edge.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings;
  - opcode and funct constants;
  - alu_op codes (add=00, sub=01, funct=10);
  - alu_control codes;
  - alu_src_b and pc_src select constants.
- One sub-module, alu_decoder: purely combinational, maps (alu_op, funct) to alu_control.

Test Plan:
- Reset: rst low mid-EXECUTE -> state_dbg returns to FETCH with no clock edge; reg_write=0; after rst goes high, FETCH outputs are alu_src_b=01, pc_src=00.
- lw (opcode 100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; reg_write=1 and mem_to_reg=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 1 for 4 cycles, then FETCH; total 7 cycles.
- R-type, funct=101010 -> alu_control=111 in EXECUTE; ALUWB has reg_dst=1 and reg_write=1.
- beq:
  - zero=1 -> pc_en=1 and pc_src=01 in BEQEX;
  - repeat with zero=0 -> pc_en=0 throughout BEQEX.
- j (000010) -> JEX has pc_src=10 and pc_en=1. Opcode 111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS main control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam int C_ST_W  = 4;
    localparam int C_ALU_W = 3;

    typedef enum logic [C_ST_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    localparam logic [5:0] C_FN_ADD = 6'b100000;
    localparam logic [5:0] C_FN_SUB = 6'b100010;
    localparam logic [5:0] C_FN_AND = 6'b100100;
    localparam logic [5:0] C_FN_OR  = 6'b100101;
    localparam logic [5:0] C_FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [C_ALU_W-1:0] C_ALU_AND = 3'b000;
    localparam logic [C_ALU_W-1:0] C_ALU_OR  = 3'b001;
    localparam logic [C_ALU_W-1:0] C_ALU_ADD = 3'b010;
    localparam logic [C_ALU_W-1:0] C_ALU_SUB = 3'b110;
    localparam logic [C_ALU_W-1:0] C_ALU_SLT = 3'b111;

    localparam logic [1:0] C_SRCB_REG    = 2'b00;
    localparam logic [1:0] C_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] C_SRCB_IMM    = 2'b10;
    localparam logic [1:0] C_SRCB_BRANCH = 2'b11;

    localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational map from (alu_op, funct) to ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_e              alu_op_i,
    input  logic [5:0]           funct_i,
    output logic [C_ALU_W-1:0]   alu_control_o
);

    always_comb begin
        alu_control_o = C_ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB:   alu_control_o = C_ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    C_FN_ADD: alu_control_o = C_ALU_ADD;
                    C_FN_SUB: alu_control_o = C_ALU_SUB;
                    C_FN_AND: alu_control_o = C_ALU_AND;
                    C_FN_OR:  alu_control_o = C_ALU_OR;
                    C_FN_SLT: alu_control_o = C_ALU_SLT;
                    default:  alu_control_o = C_ALU_ADD;
                endcase
            end
            default:     alu_control_o = C_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Moore main control FSM for the multicycle MIPS datapath with
//               memory-ready stalls in FETCH, MEMRD and MEMWR.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W    = 4,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  iord,
    output logic                  ir_write,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  pc_en,
    output logic                  illegal_op,
    output logic [STATE_W-1:0]    state_dbg
);

    state_e               state_q;
    state_e               state_d;
    alu_op_e              w_alu_op;
    logic [C_ALU_W-1:0]   w_alu_control;
    logic                 w_pc_write;
    logic                 w_branch;
    logic                 w_ir_write;
    logic                 w_mem_write;
    logic                 w_reg_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        w_alu_op    = ALUOP_ADD;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = C_SRCB_REG;
        pc_src      = C_PCSRC_ALU;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = C_SRCB_FOUR;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures PC+4 + (imm<<2) in case this is a branch
                alu_src_b = C_SRCB_BRANCH;
                case (opcode)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_RTYPE:       state_d = S_EXECUTE;
                    C_OP_BEQ:         state_d = S_BEQEX;
                    C_OP_ADDI:        state_d = S_ADDIEX;
                    C_OP_J:           state_d = S_JEX;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = C_SRCB_IMM;
                state_d   = (opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
                state_d     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_SUB;
                w_branch  = 1'b1;
                pc_src    = C_PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = C_SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JEX: begin
                pc_src     = C_PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (w_alu_op),
        .funct_i       (funct),
        .alu_control_o (w_alu_control)
    );

    // Strobes are masked by rst so nothing is written while reset is held
    assign ir_write    = rst & w_ir_write;
    assign mem_write   = rst & w_mem_write;
    assign reg_write   = rst & w_reg_write;
    assign pc_en       = rst & (w_pc_write | (w_branch & zero));
    assign alu_control = ALU_CTRL_W'(w_alu_control);
    assign state_dbg   = STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Table-driven per-cycle bench for the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;
    import mips_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, pc_en, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [19:0] exp;
    } vec_t;

    vec_t vq[$];

    multicycle_control_unit #(.STATE_W(4), .ALU_CTRL_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .iord        (iord),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .pc_en       (pc_en),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [19:0] w_bundle = {state_dbg, iord, ir_write, mem_write, reg_write, reg_dst,
                            mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control,
                            pc_en, illegal_op};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Expected-value row: st, iord, irw, memw, regw, rdst, m2r, srca, srcb, pcsrc, aluctl, pcen, ill
    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr,
                       input logic [3:0] st, input logic io, input logic irw, input logic mw,
                       input logic rw, input logic rd, input logic m2r, input logic sa,
                       input logic [1:0] sb, input logic [1:0] ps, input logic [2:0] ac,
                       input logic pe, input logic il);
        vq.push_back('{op, fn, z, mr, {st, io, irw, mw, rw, rd, m2r, sa, sb, ps, ac, pe, il}});
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr);
        opcode = op; funct = fn; zero = z; mem_ready = mr;
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    initial begin
        rst = 1'b0;
        drive(RT, 6'b100000, 1'b0, 1'b1);

        // lw, no stalls: 5 cycles
        add(LW, 0, 0, 1, 4'd0,  0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(LW, 0, 0, 1, 4'd1,  0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        add(LW, 0, 0, 1, 4'd2,  0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0);
        add(LW, 0, 0, 1, 4'd3,  1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        add(LW, 0, 0, 1, 4'd4,  0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0, 0);
        // sw: one FETCH stall, three MEMWR stalls
        add(SW, 0, 0, 0, 4'd0,  0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0, 0);
        add(SW, 0, 0, 1, 4'd0,  0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(SW, 0, 0, 1, 4'd1,  0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        add(SW, 0, 0, 1, 4'd2,  0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0);
        add(SW, 0, 0, 0, 4'd5,  1,0,1,0,0,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        add(SW, 0, 0, 0, 4'd5,  1,0,1,0,0,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        add(SW, 0, 0, 0, 4'd5,  1,0,1,0,0,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        add(SW, 0, 0, 1, 4'd5,  1,0,1,0,0,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        // R-type slt
        add(RT, 6'b101010, 0, 1, 4'd0, 0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(RT, 6'b101010, 0, 1, 4'd1, 0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        add(RT, 6'b101010, 0, 1, 4'd6, 0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b111, 0, 0);
        add(RT, 6'b101010, 0, 1, 4'd7, 0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        // R-type and / or / sub / unknown funct, checked in EXECUTE
        for (int k = 0; k < 4; k++) begin
            logic [5:0] fn;
            logic [2:0] ac;
            fn = (k == 0) ? 6'b100100 : (k == 1) ? 6'b100101 : (k == 2) ? 6'b100010 : 6'b000111;
            ac = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : (k == 2) ? 3'b110 : 3'b010;
            add(RT, fn, 0, 1, 4'd0, 0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
            add(RT, fn, 0, 1, 4'd1, 0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
            add(RT, fn, 0, 1, 4'd6, 0,0,0,0,0,0,1, 2'b00, 2'b00, ac,     0, 0);
            add(RT, fn, 0, 1, 4'd7, 0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        end
        // beq taken, then not taken
        add(BEQ, 0, 1, 1, 4'd0, 0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(BEQ, 0, 1, 1, 4'd1, 0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        add(BEQ, 0, 1, 1, 4'd8, 0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 1, 0);
        add(BEQ, 0, 0, 1, 4'd0, 0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(BEQ, 0, 0, 1, 4'd1, 0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        add(BEQ, 0, 0, 1, 4'd8, 0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0, 0);
        // addi
        add(ADDI, 0, 0, 1, 4'd0,  0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(ADDI, 0, 0, 1, 4'd1,  0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        add(ADDI, 0, 0, 1, 4'd9,  0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0);
        add(ADDI, 0, 0, 1, 4'd10, 0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        // j
        add(JMP, 0, 0, 1, 4'd0,  0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(JMP, 0, 0, 1, 4'd1,  0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        add(JMP, 0, 0, 1, 4'd11, 0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b010, 1, 0);
        // illegal opcode: pulse in DECODE, back to FETCH
        add(BAD, 0, 0, 1, 4'd0,  0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(BAD, 0, 0, 1, 4'd1,  0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 1);
        // lw with one MEMRD stall (FETCH row also confirms return from illegal)
        add(LW, 0, 0, 1, 4'd0,  0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1, 0);
        add(LW, 0, 0, 1, 4'd1,  0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        add(LW, 0, 0, 1, 4'd2,  0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0);
        add(LW, 0, 0, 0, 4'd3,  1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        add(LW, 0, 0, 1, 4'd3,  1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0, 0);
        add(LW, 0, 0, 1, 4'd4,  0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0, 0);

        // Reset held across an edge: FETCH, strobes masked despite mem_ready=1
        #1;
        check("reset_state",   32'(state_dbg), 32'd0);
        check("reset_ir_write", 32'(ir_write), 32'd0);
        check("reset_pc_en",    32'(pc_en),    32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].op, vq[i].fn, vq[i].z, vq[i].mr);
            #1;
            check($sformatf("vec%0d", i), 32'(w_bundle), 32'(vq[i].exp));
            @(negedge clk);
        end

        // Reset asserted mid-EXECUTE
        drive(RT, 6'b100000, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_execute", 32'(state_dbg), 32'd6);
        rst = 1'b0;
        #1;
        check("async_reset_state", 32'(state_dbg), 32'd0);
        check("async_reset_regw",  32'(reg_write), 32'd0);
        check("async_reset_irw",   32'(ir_write),  32'd0);
        @(posedge clk);
        #1;
        check("held_reset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_reset_srcb",  32'(alu_src_b), 32'd1);
        check("post_reset_pcsrc", 32'(pc_src),    32'd0);
        check("post_reset_irw",   32'(ir_write),  32'd1);

        // Reset asserted while a store is stalled in MEMWR
        drive(SW, 6'b000000, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("memwr_before_reset", 32'(mem_write), 32'd1);
        rst = 1'b0;
        #1;
        check("memwr_reset_mw",    32'(mem_write), 32'd0);
        check("memwr_reset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("stall_fetch_after_reset", 32'(state_dbg), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
